dircc_processing_timer_master: RTL and testbench

Avalon-MM master that drives the node's interval-timer peripheral through its 16-bit, 6-register slave map. It turns single-beat commands from the node's processing logic into register-level bus sequences: start with period, stop, 32-bit snapshot read, and status read. It also services the timer interrupt autonomously by clearing the status register and counting timeouts. It sits between the node processing core and the timer slave port, and is the initiator end of that interface.

---
 rtl/dircc_processing_timer_master.sv | 189 ++++++++++++++++++
 tb/tb_dircc_processing_timer_master.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dircc_processing_timer_master.sv
// rtl/dircc_processing_timer_master.sv - Avalon-MM master sequencing the node interval timer.
// Turns single-beat commands into timer register sequences and services the timer interrupt.
module dircc_processing_timer_master #(
  parameter logic CONTINUOUS = 1'b1,
  parameter logic IRQ_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  output logic        rsp_valid,
  output logic [31:0] rsp_snapshot,
  output logic [1:0]  rsp_status,
  output logic [15:0] timeout_count,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_WR_STOP,
    S_SNAP_WR,
    S_RD_L,
    S_RD_H,
    S_CAP_H,
    S_RD_ST,
    S_CAP_ST,
    S_DONE,
    S_IRQ_CLR,
    S_IRQ_WAIT
  } state_t;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_CONTROL = 3'd1;
  localparam logic [2:0] A_PERL    = 3'd2;
  localparam logic [2:0] A_PERH    = 3'd3;
  localparam logic [2:0] A_SNAPL   = 3'd4;
  localparam logic [2:0] A_SNAPH   = 3'd5;

  localparam logic [15:0] CTRL_START = {12'd0, 1'b0, 1'b1, CONTINUOUS, IRQ_ENABLE};
  localparam logic [15:0] CTRL_STOP  = {12'd0, 1'b1, 1'b0, CONTINUOUS, IRQ_ENABLE};

  state_t      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] timeout_count_q, timeout_count_d;

  assign cmd_ready     = (state_q == S_IDLE) && !tmr_irq;
  assign rsp_valid     = (state_q == S_DONE);
  assign rsp_snapshot  = snapshot_q;
  assign rsp_status    = status_q;
  assign timeout_count = timeout_count_q;

  always_comb begin
    state_d         = state_q;
    period_d        = period_q;
    snapshot_d      = snapshot_q;
    status_d        = status_q;
    timeout_count_d = timeout_count_q;
    case (state_q)
      S_IDLE: begin
        // A pending interrupt wins over a command presented in the same cycle.
        if (tmr_irq) begin
          state_d = S_IRQ_CLR;
        end else if (cmd_valid && cmd_ready) begin
          period_d = cmd_period;
          case (cmd_op)
            2'd0:    state_d = S_WR_PL;
            2'd1:    state_d = S_WR_STOP;
            2'd2:    state_d = S_SNAP_WR;
            default: state_d = S_RD_ST;
          endcase
        end
      end
      S_WR_PL:   state_d = S_WR_PH;
      S_WR_PH:   state_d = S_WR_CTRL;
      S_WR_CTRL: state_d = S_DONE;
      S_WR_STOP: state_d = S_DONE;
      S_SNAP_WR: state_d = S_RD_L;
      S_RD_L:    state_d = S_RD_H;
      // Slave read data lags the address by one cycle.
      S_RD_H: begin
        snapshot_d[15:0] = tmr_readdata;
        state_d          = S_CAP_H;
      end
      S_CAP_H: begin
        snapshot_d[31:16] = tmr_readdata;
        state_d           = S_DONE;
      end
      S_RD_ST:  state_d = S_CAP_ST;
      S_CAP_ST: begin
        status_d = tmr_readdata[1:0];
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      S_IRQ_CLR: begin
        timeout_count_d = timeout_count_q + 16'd1;
        state_d         = S_IRQ_WAIT;
      end
      S_IRQ_WAIT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'd0;
    case (state_q)
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERL;
        tmr_writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_PERH;
        tmr_writedata  = period_q[31:16];
      end
      S_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = CTRL_START;
      end
      S_WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_CONTROL;
        tmr_writedata  = CTRL_STOP;
      end
      S_SNAP_WR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_SNAPL;
      end
      S_RD_L: begin
        tmr_chipselect = 1'b1;
        tmr_address    = A_SNAPL;
      end
      S_RD_H: begin
        tmr_chipselect = 1'b1;
        tmr_address    = A_SNAPH;
      end
      S_RD_ST: begin
        tmr_chipselect = 1'b1;
        tmr_address    = A_STATUS;
      end
      S_IRQ_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = A_STATUS;
      end
      default: begin
        tmr_chipselect = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      period_q        <= 32'd0;
      snapshot_q      <= 32'd0;
      status_q        <= 2'd0;
      timeout_count_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      period_q        <= period_d;
      snapshot_q      <= snapshot_d;
      status_q        <= status_d;
      timeout_count_q <= timeout_count_d;
    end
  end

endmodule

// File: tb/tb_dircc_processing_timer_master.sv
// tb/tb_dircc_processing_timer_master.sv - randomized bench with a behavioural timer slave and command scoreboard.
module tb_dircc_processing_timer_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        rsp_valid;
  logic [31:0] rsp_snapshot;
  logic [1:0]  rsp_status;
  logic [15:0] timeout_count;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  always #5 clk = ~clk;

  dircc_processing_timer_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_period     (cmd_period),
    .rsp_valid      (rsp_valid),
    .rsp_snapshot   (rsp_snapshot),
    .rsp_status     (rsp_status),
    .timeout_count  (timeout_count),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq)
  );

  int n_chk = 0;
  int n_err = 0;
  int ncyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Behavioural interval-timer slave: counts down from period, flags timeout, reloads.
  logic [31:0] t_period = 32'd0;
  logic [31:0] t_cnt    = 32'd0;
  logic [31:0] t_snap   = 32'd0;
  logic        t_run    = 1'b0;
  logic        t_to     = 1'b0;
  logic        t_cont   = 1'b0;
  logic        t_ito    = 1'b0;
  logic [15:0] t_rdata  = 16'd0;
  logic [1:0]  m_stat   = 2'd0;
  int          m_events = 0;
  logic [31:0] cnt_n, per_n;
  logic        run_n, to_n;

  assign tmr_readdata = t_rdata;
  assign tmr_irq      = t_to & t_ito;

  always @(posedge clk) begin
    run_n = t_run;
    to_n  = t_to;
    cnt_n = t_cnt;
    per_n = t_period;
    if (t_run) begin
      if (t_cnt == 32'd0) begin
        to_n  = 1'b1;
        cnt_n = t_period;
        if (!t_cont) run_n = 1'b0;
      end else begin
        cnt_n = t_cnt - 32'd1;
      end
    end
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: to_n = 1'b0;
        3'd1: begin
          if (tmr_writedata[3]) run_n = 1'b0;
          if (tmr_writedata[2]) run_n = 1'b1;
          t_cont <= tmr_writedata[1];
          t_ito  <= tmr_writedata[0];
        end
        3'd2: begin per_n[15:0]  = tmr_writedata; cnt_n = per_n; run_n = 1'b0; end
        3'd3: begin per_n[31:16] = tmr_writedata; cnt_n = per_n; run_n = 1'b0; end
        3'd4, 3'd5: t_snap <= t_cnt;
        default: ;
      endcase
    end else if (tmr_chipselect) begin
      case (tmr_address)
        3'd0: begin t_rdata <= {14'd0, t_run, t_to}; m_stat <= {t_run, t_to}; end
        3'd1: t_rdata <= {12'd0, 1'b0, 1'b0, t_cont, t_ito};
        3'd2: t_rdata <= t_period[15:0];
        3'd3: t_rdata <= t_period[31:16];
        3'd4: t_rdata <= t_snap[15:0];
        3'd5: t_rdata <= t_snap[31:16];
        default: t_rdata <= 16'd0;
      endcase
    end
    if (!t_to && to_n && t_ito) m_events <= m_events + 1;
    t_run    <= run_n;
    t_to     <= to_n;
    t_cnt    <= cnt_n;
    t_period <= per_n;
  end

  typedef struct {
    int          cyc;
    logic [2:0]  a;
    logic        w;
    logic [15:0] d;
  } beat_t;

  beat_t bq[$];
  int    n_clr = 0;

  always @(negedge clk) begin
    if (tmr_chipselect) begin
      bq.push_back('{ncyc, tmr_address, !tmr_write_n, tmr_writedata});
      if (!tmr_write_n && tmr_address == 3'd0) n_clr++;
    end else begin
      check("idle_bus", {12'd0, tmr_address, tmr_write_n, tmr_writedata}, {12'd0, 3'd0, 1'b1, 16'd0});
    end
  end

  logic [31:0] exp_snap = 32'd0;
  logic [1:0]  exp_stat = 2'd0;
  int          tc_base = 0;
  int          ev_base = 0;

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] per, output int t_acc);
    beat_t exp_q[$];
    int k, lat, exp_lat, n;
    logic [31:0] g, e;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_period = per;
    k = 0;
    while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
    check("cmd_ready_wait", 32'(k < 100), 32'd1);
    t_acc = ncyc;
    bq.delete();
    @(negedge clk);
    cmd_valid  = 1'b0;
    cmd_op     = 2'($urandom);
    cmd_period = $urandom;
    k = 1;
    while (!rsp_valid && k < 20) begin @(negedge clk); k++; end
    lat = ncyc - t_acc;
    case (op)
      2'd0: begin
        exp_lat = 4;
        exp_q.push_back('{1, 3'd2, 1'b1, per[15:0]});
        exp_q.push_back('{2, 3'd3, 1'b1, per[31:16]});
        exp_q.push_back('{3, 3'd1, 1'b1, 16'h0007});
      end
      2'd1: begin
        exp_lat = 2;
        exp_q.push_back('{1, 3'd1, 1'b1, 16'h000B});
      end
      2'd2: begin
        exp_lat = 5;
        exp_q.push_back('{1, 3'd4, 1'b1, 16'h0000});
        exp_q.push_back('{2, 3'd4, 1'b0, 16'h0000});
        exp_q.push_back('{3, 3'd5, 1'b0, 16'h0000});
        exp_snap = t_snap;
      end
      default: begin
        exp_lat = 3;
        exp_q.push_back('{1, 3'd0, 1'b0, 16'h0000});
        exp_stat = m_stat;
      end
    endcase
    check($sformatf("latency_op%0d", op), lat, exp_lat);
    check($sformatf("beat_count_op%0d", op), bq.size(), exp_q.size());
    n = (bq.size() < exp_q.size()) ? bq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = {4'd0, 8'(bq[i].cyc - t_acc), bq[i].a, bq[i].w, (bq[i].w ? bq[i].d : 16'd0)};
      e = {4'd0, 8'(exp_q[i].cyc), exp_q[i].a, exp_q[i].w, exp_q[i].d};
      check($sformatf("beat%0d_op%0d", i, op), g, e);
    end
    check("rsp_snapshot", rsp_snapshot, exp_snap);
    check("rsp_status", {30'd0, rsp_status}, {30'd0, exp_stat});
    @(negedge clk);
    check("rsp_pulse_width", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic quiesce();
    int t;
    do_cmd(2'd1, 32'd0, t);
    repeat (10) @(negedge clk);
    check("timeout_count", {16'd0, timeout_count}, {16'd0, 16'(tc_base + m_events - ev_base)});
    check("clear_writes", n_clr, m_events);
  endtask

  int t, i_cyc, k;

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_period = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_snapshot", rsp_snapshot, 32'd0);
    check("rst_status", {30'd0, rsp_status}, 32'd0);
    check("rst_timeout_count", {16'd0, timeout_count}, 32'd0);
    reset_n = 1'b1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Start with a long period, then stop and read status.
    do_cmd(2'd0, 32'h0001_86A0, t);
    check("timer_running", {31'd0, t_run}, 32'd1);
    check("timer_period", t_period, 32'h0001_86A0);
    quiesce();
    do_cmd(2'd3, 32'd0, t);
    check("status_after_stop", {30'd0, rsp_status}, 32'd0);

    // Snapshot of a running period-10 timer.
    do_cmd(2'd0, 32'd10, t);
    repeat (3) @(negedge clk);
    do_cmd(2'd2, 32'd0, t);
    quiesce();

    // Interrupt and command collide in IDLE: interrupt is serviced first.
    do_cmd(2'd0, 32'd3, t);
    k = 0;
    while (!tmr_irq && k < 50) begin @(negedge clk); k++; end
    check("irq_seen", 32'(k < 50), 32'd1);
    i_cyc = ncyc;
    check("ready_low_on_irq", {31'd0, cmd_ready}, 32'd0);
    do_cmd(2'd3, 32'd0, t);
    check("irq_priority_accept", t - i_cyc, 32'd3);
    k = m_events;
    while (m_events < k + 3 && ncyc < 5000) @(negedge clk);
    quiesce();

    // Random command mix while the timer keeps interrupting.
    for (int i = 0; i < 30; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_cmd(op, 32'($urandom_range(2, 40)), t);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    quiesce();

    // Counter wrap from 0xFFFF.
    force dut.timeout_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.timeout_count_q;
    tc_base = 16'hFFFF;
    ev_base = m_events;
    do_cmd(2'd0, 32'd50, t);
    k = 0;
    while (m_events == ev_base && k < 200) begin @(negedge clk); k++; end
    check("wrap_irq_seen", 32'(k < 200), 32'd1);
    quiesce();
    check("timeout_wrap", {16'd0, timeout_count}, 32'd0);

    // Make the held snapshot nonzero, then reset during RD_H of another snapshot.
    do_cmd(2'd0, 32'd1000, t);
    repeat (4) @(negedge clk);
    do_cmd(2'd2, 32'd0, t);
    quiesce();
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    check("rd_h_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rd_h_beat", {28'd0, tmr_chipselect, tmr_address}, {28'd0, 1'b1, 3'd5});
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_bus", {12'd0, tmr_chipselect, tmr_address, tmr_write_n, tmr_writedata}, {12'd0, 1'b0, 3'd0, 1'b1, 16'd0});
    check("abort_snapshot", rsp_snapshot, 32'd0);
    check("abort_count", {16'd0, timeout_count}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    reset_n  = 1'b1;
    tc_base  = 0;
    ev_base  = m_events;
    exp_snap = 32'd0;
    exp_stat = 2'd0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_cmd(2'd3, 32'd0, t);
    quiesce();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
